// File: rtl/shift_deserializer.sv
// shift_deserializer
//   Serial-in/parallel-out receiver. Reassembles N-bit words from a framed
//   serial bit stream, MSB first or LSB first, and presents each word on a
//   valid/ready output port.
//
// Parameters
//   N          word width in bits (N >= 1)
//   MSB_FIRST  1: first received bit lands in data_out[N-1]; 0: in data_out[0]
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   bit_in       in   serial data bit
//   bit_valid    in   bit_in is sampled on this edge
//   bit_start    in   with bit_valid: this bit is the first bit of a word
//   data_out     out  assembled word, stable while out_valid=1
//   out_valid    out  data_out holds an unconsumed word
//   out_ready    in   consumer accepts the word when out_valid && out_ready
//   busy         out  partial word in progress
//   overrun      out  1-cycle pulse: completed word dropped, output still full
//   frame_error  out  1-cycle pulse: bit_start arrived mid-word
module shift_deserializer #(
    parameter int unsigned N         = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         bit_in,
    input  logic         bit_valid,
    input  logic         bit_start,
    output logic [N-1:0] data_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         overrun,
    output logic         frame_error
);

    localparam int unsigned     CntW    = $clog2(N + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(N);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e          state_q;
    logic [N-1:0]    sr_q;
    logic [CntW-1:0] cnt_q;

    logic [N-1:0]    sr_ins;
    logic [CntW-1:0] cnt_next;
    logic            accept;
    logic            restart;
    logic            complete;

    // Shift register contents once the current bit has been inserted.
    generate
        if (N == 1) begin : g_single
            assign sr_ins = bit_in;
        end else if (MSB_FIRST) begin : g_msb
            assign sr_ins = {sr_q[N-2:0], bit_in};
        end else begin : g_lsb
            assign sr_ins = {bit_in, sr_q[N-1:1]};
        end
    endgenerate

    always_comb begin
        // Bits outside a frame are ignored unless they open a new one.
        accept   = bit_valid && (bit_start || (state_q == StShift));
        restart  = bit_valid && bit_start && (state_q == StShift);
        cnt_next = bit_start ? CntW'(1) : cnt_q + CntW'(1);
        complete = accept && (cnt_next == CntFull);
    end

    assign busy = (state_q == StShift);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            sr_q        <= '0;
            cnt_q       <= '0;
            data_out    <= '0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            overrun     <= 1'b0;
            frame_error <= restart;

            // A restart simply reseeds the count; the stale partial bits are
            // shifted out before the new word can complete.
            if (accept) begin
                sr_q <= sr_ins;
                if (complete) begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end else begin
                    state_q <= StShift;
                    cnt_q   <= cnt_next;
                end
            end

            // A completion may reuse the output slot on the same edge it is drained.
            if (complete) begin
                if (!out_valid || out_ready) begin
                    data_out  <= sr_ins;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_deserializer.sv
module tb_shift_deserializer;

    logic clock = 1'b0;
    logic reset;
    logic bit_in, bit_valid, bit_start, out_ready;

    logic [7:0] m_data, l_data;
    logic m_valid, m_busy, m_ovr, m_fe;
    logic l_valid, l_busy, l_ovr, l_fe;

    logic n_bit, n_bvalid, n_start, n_ready;
    logic [0:0] n_data;
    logic n_valid, n_busy, n_ovr, n_fe;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    shift_deserializer #(.N(8), .MSB_FIRST(1'b1)) u_msb (
        .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_start(bit_start), .data_out(m_data), .out_valid(m_valid),
        .out_ready(out_ready), .busy(m_busy), .overrun(m_ovr), .frame_error(m_fe)
    );

    shift_deserializer #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
        .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_start(bit_start), .data_out(l_data), .out_valid(l_valid),
        .out_ready(out_ready), .busy(l_busy), .overrun(l_ovr), .frame_error(l_fe)
    );

    shift_deserializer #(.N(1), .MSB_FIRST(1'b1)) u_n1 (
        .clock(clock), .reset(reset), .bit_in(n_bit), .bit_valid(n_bvalid),
        .bit_start(n_start), .data_out(n_data), .out_valid(n_valid),
        .out_ready(n_ready), .busy(n_busy), .overrun(n_ovr), .frame_error(n_fe)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bit_valid = 1'b0;
        bit_start = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input bit msb_order);
        for (int i = 0; i < 8; i++) begin
            bit_in    = msb_order ? w[7-i] : w[i];
            bit_valid = 1'b1;
            bit_start = (i == 0);
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        out_ready = 1'b0;
        n_bit = 1'b0; n_bvalid = 1'b0; n_start = 1'b0; n_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        checks++;
        if ({m_data, m_valid, m_busy, m_ovr, m_fe} !== 12'h000) begin
            errors++;
            $display("FAIL reset_msb got data=%h v=%b b=%b o=%b f=%b exp all 0",
                     m_data, m_valid, m_busy, m_ovr, m_fe);
        end
        checks++;
        if ({n_data, n_valid, n_busy, n_ovr, n_fe} !== 5'b0) begin
            errors++;
            $display("FAIL reset_n1 got data=%b v=%b b=%b o=%b f=%b exp all 0",
                     n_data, n_valid, n_busy, n_ovr, n_fe);
        end
    endtask

    task automatic test_msb_basic();
        logic [7:0] w;
        bit early;
        int hi_cycles;
        w = 8'hA5;
        early = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bit_in = w[7-i]; bit_valid = 1'b1; bit_start = (i == 0);
            step();
            if (i < 7 && m_valid) early = 1'b1;
        end
        idle_inputs();
        checks++;
        if (early) begin
            errors++;
            $display("FAIL msb_early_valid got out_valid=1 before 8th bit exp 0");
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
            errors++;
            $display("FAIL msb_word got v=%b data=%h exp v=1 data=a5", m_valid, m_data);
        end
        hi_cycles = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (m_valid) hi_cycles++;
        end
        checks++;
        if (hi_cycles != 1 || m_data !== 8'hA5) begin
            errors++;
            $display("FAIL msb_valid_len got %0d cycles data=%h exp 1 cycle data=a5",
                     hi_cycles, m_data);
        end
    endtask

    task automatic test_lsb_gaps();
        logic [7:0] w;
        bit busy_drop;
        int gap;
        w = 8'h3C;
        busy_drop = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bit_in = w[i]; bit_valid = 1'b1; bit_start = (i == 0);
            step();
            idle_inputs();
            if (i == 7) begin
                checks++;
                if (l_valid !== 1'b1 || l_data !== 8'h3C || l_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL lsb_word got v=%b data=%h busy=%b exp v=1 data=3c busy=0",
                             l_valid, l_data, l_busy);
                end
            end else begin
                gap = $urandom_range(0, 3);
                if (!l_busy) busy_drop = 1'b1;
                for (int g = 0; g < gap; g++) begin
                    step();
                    if (!l_busy) busy_drop = 1'b1;
                end
            end
        end
        checks++;
        if (busy_drop) begin
            errors++;
            $display("FAIL lsb_busy_gap got busy=0 mid-word exp 1");
        end
        step();
        checks++;
        if (l_valid !== 1'b0) begin
            errors++;
            $display("FAIL lsb_consume got v=%b exp 0", l_valid);
        end
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        send_word(8'h11, 1'b1);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h11 || m_ovr !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first got v=%b data=%h ovr=%b exp v=1 data=11 ovr=0",
                     m_valid, m_data, m_ovr);
        end
        send_word(8'h22, 1'b1);
        checks++;
        if (m_ovr !== 1'b1 || m_data !== 8'h11 || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovr_pulse got ovr=%b data=%h v=%b exp ovr=1 data=11 v=1",
                     m_ovr, m_data, m_valid);
        end
        step();
        checks++;
        if (m_ovr !== 1'b0) begin
            errors++;
            $display("FAIL ovr_width got ovr=%b exp 0", m_ovr);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h11) begin
            errors++;
            $display("FAIL ovr_drain got v=%b data=%h exp v=0 data=11", m_valid, m_data);
        end
    endtask

    task automatic test_frame_error();
        logic [4:0] part;
        logic [7:0] w;
        bit stray;
        part = 5'b10110;
        w = 8'hF0;
        stray = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bit_in = part[4-i]; bit_valid = 1'b1; bit_start = (i == 0);
            step();
            if (m_valid || m_fe) stray = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            bit_in = w[7-i]; bit_valid = 1'b1; bit_start = (i == 0);
            step();
            if (i == 0) begin
                checks++;
                if (m_fe !== 1'b1 || m_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL fe_pulse got fe=%b busy=%b exp fe=1 busy=1", m_fe, m_busy);
                end
            end else if (i < 7 && (m_fe || m_valid)) begin
                stray = 1'b1;
            end
        end
        idle_inputs();
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL fe_stray got extra fe/valid exp none");
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hF0 || m_fe !== 1'b0) begin
            errors++;
            $display("FAIL fe_word got v=%b data=%h fe=%b exp v=1 data=f0 fe=0",
                     m_valid, m_data, m_fe);
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bit_in = 1'b1; bit_valid = 1'b1; bit_start = (i == 0);
            step();
        end
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({m_data, m_valid, m_busy, m_ovr, m_fe} !== 12'h000) begin
            errors++;
            $display("FAIL rst_mid got data=%h v=%b busy=%b exp all 0", m_data, m_valid, m_busy);
        end
        send_word(8'h81, 1'b1);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h81) begin
            errors++;
            $display("FAIL rst_next got v=%b data=%h exp v=1 data=81", m_valid, m_data);
        end
        out_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_full got v=%b data=%h exp v=0 data=00", m_valid, m_data);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send_word(8'h5A, 1'b1);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h5A) begin
            errors++;
            $display("FAIL b2b_first got v=%b data=%h exp v=1 data=5a", m_valid, m_data);
        end
        send_word(8'hC3, 1'b1);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hC3 || m_ovr !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got v=%b data=%h ovr=%b exp v=1 data=c3 ovr=0",
                     m_valid, m_data, m_ovr);
        end
        step();
    endtask

    task automatic test_n1();
        logic [2:0] seq;
        seq = 3'b101;
        n_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_bit = seq[2-i]; n_bvalid = 1'b1; n_start = 1'b1;
            step();
            checks++;
            if (n_valid !== 1'b1 || n_data !== seq[2-i] || n_busy !== 1'b0) begin
                errors++;
                $display("FAIL n1_word%0d got v=%b data=%b busy=%b exp v=1 data=%b busy=0",
                         i, n_valid, n_data, n_busy, seq[2-i]);
            end
        end
        n_bvalid = 1'b0; n_start = 1'b0;
        step();
        checks++;
        if (n_valid !== 1'b0) begin
            errors++;
            $display("FAIL n1_drain got v=%b exp 0", n_valid);
        end
    endtask

    // Reference: collect bits of an open frame, place them by arrival order,
    // and track a single-entry output slot.
    task automatic test_random();
        bit in_word;
        int cnt;
        logic [7:0] am, al, edm, edl;
        bit ev, eovr, efe, comp;
        bit v, s, b, r;
        reset = 1'b1;
        idle_inputs();
        step();
        reset = 1'b0;
        in_word = 0; cnt = 0; am = 0; al = 0; edm = 0; edl = 0; ev = 0;
        for (int c = 0; c < 400; c++) begin
            v = ($urandom_range(0, 3) != 0);
            s = in_word ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1);
            b = $urandom_range(0, 1);
            r = ($urandom_range(0, 2) != 0);
            bit_in = b; bit_valid = v; bit_start = s; out_ready = r;

            efe = 0; eovr = 0; comp = 0;
            if (v && (s || in_word)) begin
                if (s) begin
                    efe = in_word;
                    in_word = 1; cnt = 1;
                    am = 8'(b);
                    al = 8'h00;
                    al[0] = b;
                end else begin
                    am = (am << 1) | 8'(b);
                    al[cnt] = b;
                    cnt++;
                end
                if (cnt == 8) begin
                    comp = 1;
                    in_word = 0;
                end
            end
            if (comp) begin
                if (!ev || r) begin
                    ev = 1; edm = am; edl = al;
                end else begin
                    eovr = 1;
                end
            end else if (ev && r) begin
                ev = 0;
            end

            step();
            checks++;
            if ({m_valid, m_data, m_busy, m_ovr, m_fe} !== {ev, edm, in_word, eovr, efe}) begin
                errors++;
                $display("FAIL rand_msb c%0d got v=%b d=%h b=%b o=%b f=%b exp v=%b d=%h b=%b o=%b f=%b",
                         c, m_valid, m_data, m_busy, m_ovr, m_fe, ev, edm, in_word, eovr, efe);
            end
            checks++;
            if ({l_valid, l_data, l_busy, l_ovr, l_fe} !== {ev, edl, in_word, eovr, efe}) begin
                errors++;
                $display("FAIL rand_lsb c%0d got v=%b d=%h b=%b o=%b f=%b exp v=%b d=%h b=%b o=%b f=%b",
                         c, l_valid, l_data, l_busy, l_ovr, l_fe, ev, edl, in_word, eovr, efe);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_msb_basic();
        test_lsb_gaps();
        test_overrun();
        test_frame_error();
        test_reset_mid();
        test_back_to_back();
        test_n1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
